// File: rtl/objf_pkg.sv
// Shared types and constants for the objective-function parameter loader.
//   coef_t         : one coefficient / ID word
//   bank_sel_e     : write target array (coefficients or IDs)
//   loader_state_e : launch controller states
//   TRANS_IDX      : coefficient index of the translation term
package objf_pkg;

  localparam int unsigned OBJF_DATA_WIDTH = 32;
  localparam int unsigned TRANS_IDX       = 6;

  typedef logic [OBJF_DATA_WIDTH-1:0] coef_t;

  typedef enum logic {
    SEL_COEF = 1'b0,
    SEL_ID   = 1'b1
  } bank_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LAUNCH = 2'd2,
    RUN    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/objf_bank_regs.sv
// One parameter bank: NUM_COEF coefficient words plus NUM_ID ID words.
//   clk, rst           : clock, asynchronous active-low reset (clears all words)
//   wr_en/sel/addr/data: single-word write; addresses outside the array are ignored
//   load, load_coef/id : parallel load of the whole bank (has priority over a write)
//   coef_out, id_out   : flat word outputs, word i at [i*DATA_WIDTH +: DATA_WIDTH]
module objf_bank_regs
  import objf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_COEF   = 10,
  parameter int unsigned NUM_ID     = 50,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           load,
  input  logic [DATA_WIDTH*NUM_COEF-1:0] load_coef,
  input  logic [DATA_WIDTH*NUM_ID-1:0]   load_id,
  output logic [DATA_WIDTH*NUM_COEF-1:0] coef_out,
  output logic [DATA_WIDTH*NUM_ID-1:0]   id_out
);

  logic [DATA_WIDTH-1:0] coef_q [NUM_COEF];
  logic [DATA_WIDTH-1:0] id_q   [NUM_ID];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
      for (int i = 0; i < NUM_ID; i++)   id_q[i]   <= '0;
    end else begin
      // Address decode by comparison so out-of-range indices simply match nothing.
      for (int i = 0; i < NUM_COEF; i++) begin
        if (load) begin
          coef_q[i] <= load_coef[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_en && (wr_sel == SEL_COEF) && (wr_addr == ADDR_WIDTH'(i))) begin
          coef_q[i] <= wr_data;
        end
      end
      for (int i = 0; i < NUM_ID; i++) begin
        if (load) begin
          id_q[i] <= load_id[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_en && (wr_sel == SEL_ID) && (wr_addr == ADDR_WIDTH'(i))) begin
          id_q[i] <= wr_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_COEF; g++) begin : g_coef_out
    assign coef_out[g*DATA_WIDTH +: DATA_WIDTH] = coef_q[g];
  end

  for (genvar g = 0; g < NUM_ID; g++) begin : g_id_out
    assign id_out[g*DATA_WIDTH +: DATA_WIDTH] = id_q[g];
  end

endmodule

// File: rtl/objf_param_loader.sv
// Double-buffered parameter store and launch controller for the objective-function core.
//   clk, rst            : clock, asynchronous active-low reset
//   wr_valid/ready      : write handshake into the shadow bank (ready in IDLE and RUN)
//   wr_sel/addr/data    : target array, word index, data
//   commit              : shadow bank complete; request a launch
//   err_clr             : clear the sticky out-of-range flag
//   core_busy/core_done : core status
//   op_objfunc          : one-cycle start pulse to the core
//   coef_out, id_out    : active-bank contents
//   active_bank         : index of the active bank
//   pending             : commit accepted but not yet launched
//   err_addr            : sticky out-of-range write flag
module objf_param_loader
  import objf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_COEF   = 10,
  parameter int unsigned NUM_ID     = 50,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic                           wr_sel,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           commit,
  input  logic                           err_clr,
  input  logic                           core_busy,
  input  logic                           core_done,
  output logic                           op_objfunc,
  output logic [DATA_WIDTH*NUM_COEF-1:0] coef_out,
  output logic [DATA_WIDTH*NUM_ID-1:0]   id_out,
  output logic                           active_bank,
  output logic                           pending,
  output logic                           err_addr
);

  loader_state_e state_q;
  logic          active_q;
  logic          op_q;
  logic          pending_q;
  logic          err_q;

  logic          wr_fire;
  logic          addr_ok;
  logic          bank_wr_en [2];
  logic          bank_load  [2];

  logic [DATA_WIDTH*NUM_COEF-1:0] bank_coef [2];
  logic [DATA_WIDTH*NUM_ID-1:0]   bank_id   [2];

  assign wr_ready = (state_q == IDLE) || (state_q == RUN);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    addr_ok = 1'b0;
    if (wr_sel == SEL_ID) begin
      addr_ok = 32'(wr_addr) < NUM_ID;
    end else begin
      addr_ok = 32'(wr_addr) < NUM_COEF;
    end
  end

  // Writes go to the shadow bank; on LAUNCH the old active bank copies the old shadow so
  // the next shadow starts from the parameter set that is about to go live.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_wr_en[b] = wr_fire && addr_ok && (active_q != 1'(b));
      bank_load[b]  = (state_q == LAUNCH) && (active_q == 1'(b));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    objf_bank_regs #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_COEF   (NUM_COEF),
      .NUM_ID     (NUM_ID),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bank_wr_en[g]),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .load      (bank_load[g]),
      .load_coef (bank_coef[1-g]),
      .load_id   (bank_id[1-g]),
      .coef_out  (bank_coef[g]),
      .id_out    (bank_id[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      op_q      <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      op_q <= 1'b0;

      // A new out-of-range write wins over a simultaneous clear.
      if (wr_fire && !addr_ok) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (commit) begin
            state_q   <= ARMED;
            pending_q <= 1'b1;
          end
        end
        ARMED: begin
          if (!core_busy) begin
            state_q <= LAUNCH;
            op_q    <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q   <= RUN;
          active_q  <= ~active_q;
          pending_q <= 1'b0;
        end
        RUN: begin
          if (commit) pending_q <= 1'b1;
          if (core_done) begin
            state_q <= (pending_q || commit) ? ARMED : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_objfunc  = op_q;
  assign active_bank = active_q;
  assign pending     = pending_q;
  assign err_addr    = err_q;
  assign coef_out    = active_q ? bank_coef[1] : bank_coef[0];
  assign id_out      = active_q ? bank_id[1]   : bank_id[0];

endmodule
